// File: rtl/instr_fetch_pkg.sv
// Shared widths and entry layout for the instruction fetch stage.
// The instruction space is 1024 words, so only 10 PC bits are significant.
package instr_fetch_pkg;

   localparam int IADDR_W    = 12;
   localparam int INSTR_W    = 32;
   localparam int IMEM_WORDS = 1024;
   localparam logic [IADDR_W-1:0] PC_MASK = IADDR_W'(IMEM_WORDS - 1);
   localparam int ENTRY_W    = IADDR_W + INSTR_W;

   typedef struct packed {
      logic [IADDR_W-1:0] pc;
      logic [INSTR_W-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small instruction buffer of {pc,instr} entries with flush and occupancy count.
// The head is presented combinationally and reads as zero while the buffer is empty.
module fetch_fifo
   import instr_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic                            push,
   input  logic [ENTRY_W-1:0]              push_data,
   input  logic                            pop,
   output logic [ENTRY_W-1:0]              head,
   output logic [$clog2(DEPTH+1)-1:0]      count
);

   localparam int PTR_W = (DEPTH > 2) ? 2 : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);

   logic [ENTRY_W-1:0] mem_reg [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic               push_ok;
   logic               pop_ok;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign push_ok = push && (count_reg < CNT_W'(DEPTH));
   assign pop_ok  = pop && (count_reg != '0);
   assign count   = count_reg;
   assign head    = (count_reg != '0) ? mem_reg[rd_ptr_reg] : '0;

   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   // Flush discards everything, including a push or pop in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= next_ptr(wr_ptr_reg);
         end
         if (pop_ok) begin
            rd_ptr_reg <= next_ptr(rd_ptr_reg);
         end
         case ({push_ok, pop_ok})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC, single outstanding read, and buffering toward decode.
// Reads are issued only when the buffer is guaranteed room for the response.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [IADDR_W-1:0] RESET_PC   = 12'h000,
   parameter int                 FIFO_DEPTH = 2
) (
   input  logic               clk,
   input  logic               rst,
   output logic [IADDR_W-1:0] instr_addr,
   output logic               instr_re,
   input  logic [INSTR_W-1:0] instr_rd_data,
   input  logic               redirect,
   input  logic [IADDR_W-1:0] redirect_pc,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [IADDR_W-1:0] if_pc,
   input  logic               id_ready
);

   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OCC_W = CNT_W + 1;

   logic [IADDR_W-1:0] pc_reg;
   logic [IADDR_W-1:0] inflight_pc_reg;
   logic               inflight_reg;
   logic [CNT_W-1:0]   fifo_count;
   logic [OCC_W-1:0]   occupancy;
   logic               pop;
   logic               push;
   logic [ENTRY_W-1:0] head;
   fetch_entry_t       head_entry;
   fetch_entry_t       push_entry;

   assign if_valid  = (fifo_count != '0);
   assign pop       = if_valid & id_ready;
   // A response returning alongside redirect or reset belongs to the old stream.
   assign push      = inflight_reg & ~redirect & ~rst;
   assign occupancy = {1'b0, fifo_count} + OCC_W'(inflight_reg) - OCC_W'(pop);
   assign instr_re  = ~rst & ~redirect & (occupancy < OCC_W'(FIFO_DEPTH));
   assign instr_addr = pc_reg;

   assign push_entry.pc    = inflight_pc_reg;
   assign push_entry.instr = instr_rd_data;
   assign head_entry       = head;
   assign if_pc            = head_entry.pc;
   assign if_instr         = head_entry.instr;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_reg          <= RESET_PC & PC_MASK;
         inflight_reg    <= 1'b0;
         inflight_pc_reg <= '0;
      end else if (redirect) begin
         pc_reg       <= redirect_pc & PC_MASK;
         inflight_reg <= 1'b0;
      end else begin
         inflight_reg <= instr_re;
         if (instr_re) begin
            pc_reg          <= (pc_reg + IADDR_W'(1)) & PC_MASK;
            inflight_pc_reg <= pc_reg;
         end
      end
   end

   fetch_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .flush     (redirect),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count)
   );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a registered-read memory where word n holds n.
// Inputs change and outputs are sampled just after the falling edge.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] instr_addr;
   logic        instr_re;
   logic [31:0] instr_rd_data;
   logic        redirect;
   logic [11:0] redirect_pc;
   logic        if_valid;
   logic [31:0] if_instr;
   logic [11:0] if_pc;
   logic        id_ready;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (instr_re) instr_rd_data <= {20'h0, instr_addr};
   end

   instr_fetch #(
      .RESET_PC   (12'h000),
      .FIFO_DEPTH (2)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .instr_addr    (instr_addr),
      .instr_re      (instr_re),
      .instr_rd_data (instr_rd_data),
      .redirect      (redirect),
      .redirect_pc   (redirect_pc),
      .if_valid      (if_valid),
      .if_instr      (if_instr),
      .if_pc         (if_pc),
      .id_ready      (id_ready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks valid and, when valid, pc/instr; when empty, pc/instr must read zero.
   task automatic chk_out(input string tag, input logic v, input logic [11:0] pc);
      chk({tag, "_valid"}, {31'h0, if_valid}, {31'h0, v});
      chk({tag, "_pc"}, {20'h0, if_pc}, v ? {20'h0, pc} : 32'h0);
      chk({tag, "_instr"}, if_instr, v ? {20'h0, pc} : 32'h0);
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   initial begin
      rst = 1'b1; redirect = 1'b0; redirect_pc = 12'h0; id_ready = 1'b1;
      repeat (3) step();
      #1;
      chk_out("reset", 1'b0, 12'h0);
      chk("reset_re", {31'h0, instr_re}, 32'h0);

      // First fetch issues in the first cycle out of reset.
      step(); rst = 1'b0; #1;
      chk("c0_re", {31'h0, instr_re}, 32'h1);
      chk("c0_addr", {20'h0, instr_addr}, 32'h000);
      chk_out("c0", 1'b0, 12'h0);
      step(); #1;
      chk_out("c1", 1'b0, 12'h0);
      chk("c1_addr", {20'h0, instr_addr}, 32'h001);
      for (int i = 0; i < 6; i++) begin
         step(); #1;
         chk_out("stream", 1'b1, 12'(i));
         chk("stream_re", {31'h0, instr_re}, 32'h1);
      end

      // Stall: head 5 held, buffer fills with 6, no further reads.
      id_ready = 1'b0; #1;
      chk("stall_re_comb", {31'h0, instr_re}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(); #1;
         chk_out("stall", 1'b1, 12'h005);
         chk("stall_re", {31'h0, instr_re}, 32'h0);
      end
      chk("stall_count", {30'h0, dut.fifo_count}, 32'h2);
      id_ready = 1'b1; #1;
      chk("release_re", {31'h0, instr_re}, 32'h1);
      chk("release_addr", {20'h0, instr_addr}, 32'h007);
      for (int i = 6; i < 9; i++) begin
         step(); #1;
         chk_out("resume", 1'b1, 12'(i));
      end

      // Fill, then redirect while full.
      id_ready = 1'b0;
      step(); #1;
      chk_out("full", 1'b1, 12'h008);
      chk("full_count", {30'h0, dut.fifo_count}, 32'h2);
      redirect = 1'b1; redirect_pc = 12'h100; id_ready = 1'b1; #1;
      chk("redir_re", {31'h0, instr_re}, 32'h0);
      step(); redirect = 1'b0; #1;
      chk_out("redir_b1", 1'b0, 12'h0);
      chk("redir_re1", {31'h0, instr_re}, 32'h1);
      chk("redir_addr", {20'h0, instr_addr}, 32'h100);
      step(); #1;
      chk_out("redir_b2", 1'b0, 12'h0);
      step(); #1;
      chk_out("redir_tgt", 1'b1, 12'h100);
      step(); #1;
      chk_out("redir_tgt1", 1'b1, 12'h101);

      // Redirect coinciding with a returning response; then wrap past 0x3FF.
      redirect = 1'b1; redirect_pc = 12'h3FE;
      step(); redirect = 1'b0; #1;
      chk_out("wrap_b1", 1'b0, 12'h0);
      chk("wrap_addr0", {20'h0, instr_addr}, 32'h3FE);
      step(); #1;
      chk_out("wrap_b2", 1'b0, 12'h0);
      chk("wrap_addr1", {20'h0, instr_addr}, 32'h3FF);
      step(); #1;
      chk_out("wrap_3fe", 1'b1, 12'h3FE);
      chk("wrap_addr2", {20'h0, instr_addr}, 32'h000);
      step(); #1;
      chk_out("wrap_3ff", 1'b1, 12'h3FF);
      chk("wrap_addr_hi", {30'h0, instr_addr[11:10]}, 32'h0);
      step(); #1;
      chk_out("wrap_000", 1'b1, 12'h000);
      chk("wrap_addr3", {20'h0, instr_addr}, 32'h002);

      // Upper redirect bits are ignored.
      redirect = 1'b1; redirect_pc = 12'hC05;
      step(); redirect = 1'b0; #1;
      chk("mask_addr", {20'h0, instr_addr}, 32'h005);
      step(); #1;
      chk_out("mask_b2", 1'b0, 12'h0);
      step(); #1;
      chk_out("mask_tgt", 1'b1, 12'h005);

      // Back-to-back redirects: the second wins, first target never delivered.
      redirect = 1'b1; redirect_pc = 12'h200;
      step(); redirect_pc = 12'h050; #1;
      chk("b2b_re", {31'h0, instr_re}, 32'h0);
      chk_out("b2b_mid", 1'b0, 12'h0);
      step(); redirect = 1'b0; #1;
      chk("b2b_addr", {20'h0, instr_addr}, 32'h050);
      chk_out("b2b_b1", 1'b0, 12'h0);
      step(); #1;
      chk_out("b2b_b2", 1'b0, 12'h0);
      step(); #1;
      chk_out("b2b_tgt", 1'b1, 12'h050);
      step(); #1;
      chk_out("b2b_tgt1", 1'b1, 12'h051);

      // One-cycle reset with a read in flight; reset overrides a redirect.
      id_ready = 1'b0; rst = 1'b1; redirect = 1'b1; redirect_pc = 12'h222; #1;
      chk("rst2_re", {31'h0, instr_re}, 32'h0);
      step(); rst = 1'b0; redirect = 1'b0; id_ready = 1'b1; #1;
      chk_out("rst2_c0", 1'b0, 12'h0);
      chk("rst2_addr", {20'h0, instr_addr}, 32'h000);
      chk("rst2_re1", {31'h0, instr_re}, 32'h1);
      step(); #1;
      chk_out("rst2_c1", 1'b0, 12'h0);
      step(); #1;
      chk_out("rst2_first", 1'b1, 12'h000);
      step(); #1;
      chk_out("rst2_second", 1'b1, 12'h001);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
